// File: rtl/exotiny_qspi_pkg.sv
// Shared types and constants for the ExoTiny QSPI memory responder.
//   qspi_state_e   : frame-decoder state
//   QSPI_CMD_RD/WR : default quad read / quad write opcodes
//   QSPI_ADDR_NIB  : address nibbles per frame (24-bit bus address)
package exotiny_qspi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } qspi_state_e;

  localparam logic [7:0] QSPI_CMD_RD   = 8'hEB;
  localparam logic [7:0] QSPI_CMD_WR   = 8'h38;
  localparam int         QSPI_ADDR_NIB = 6;
endpackage

// File: rtl/exotiny_qspi_resp_if.sv
// Bus bundle for the QSPI responder: QSPI pins on one side, byte-wide
// synchronous SRAM port plus error pulse on the other.
//   slave  : the responder (drives sd_o/sd_oen_o, mem_* strobes, err_o)
//   master : initiator + memory model (drives cs/sck/sd_i, mem_rdata_i)
interface exotiny_qspi_resp_if #(
  parameter int MEM_AW = 12
);
  logic              cs_in;
  logic              sck_i;
  logic [3:0]        sd_i;
  logic [3:0]        sd_o;
  logic [3:0]        sd_oen_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic              mem_re_o;
  logic              mem_we_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;
  logic              err_o;

  modport slave (
    input  cs_in, sck_i, sd_i, mem_rdata_i,
    output sd_o, sd_oen_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, err_o
  );

  modport master (
    output cs_in, sck_i, sd_i, mem_rdata_i,
    input  sd_o, sd_oen_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/exotiny_qspi_sync.sv
// W-bit 2-flop synchronizer with registered rise/fall pulses.
//   d_i    : asynchronous input
//   q_o    : synchronized value, aligned with the rise/fall pulses so that
//            data synced through an identical instance is sampled coherently
//   rise_o : one-cycle pulse per bit on a 0->1 change
//   fall_o : one-cycle pulse per bit on a 1->0 change
module exotiny_qspi_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_in,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] s1_q, s2_q, s3_q, rise_q, fall_q;
  logic [W-1:0] rise_d, fall_d;

  always_comb begin
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      s3_q   <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = s3_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/exotiny_qspi_resp.sv
// QSPI memory responder. Oversamples cs/sck/sd in clk_i, decodes quad read
// and quad write frames (opcode, 24-bit address, dummy/data) and serves
// them from a byte-wide synchronous SRAM port.
//   clk_i, rst_in : system clock, async active-low reset
//   bus (slave)   : QSPI pins, SRAM port (addr/re/we/wdata/rdata), err_o
module exotiny_qspi_resp
  import exotiny_qspi_pkg::*;
#(
  parameter int          MEM_AW    = 12,
  parameter int          DUMMY_CYC = 6,
  parameter logic [7:0]  CMD_RD    = QSPI_CMD_RD,
  parameter logic [7:0]  CMD_WR    = QSPI_CMD_WR
) (
  input logic                 clk_i,
  input logic                 rst_in,
  exotiny_qspi_resp_if.slave  bus
);
  logic       cs_q, cs_rise, cs_fall;
  logic       sck_q, sck_rise, sck_fall;
  logic [3:0] sd_q, sd_rise, sd_fall;
  logic       unused_sync;

  exotiny_qspi_sync #(.W(1), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i, .rst_in, .d_i(bus.cs_in), .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall));
  exotiny_qspi_sync #(.W(1), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i, .rst_in, .d_i(bus.sck_i), .q_o(sck_q), .rise_o(sck_rise), .fall_o(sck_fall));
  exotiny_qspi_sync #(.W(4), .RST_VAL(4'h0)) u_sync_sd (
    .clk_i, .rst_in, .d_i(bus.sd_i), .q_o(sd_q), .rise_o(sd_rise), .fall_o(sd_fall));

  assign unused_sync = ^{cs_q, sck_q, sd_rise, sd_fall};

  qspi_state_e       state_q, state_d;
  logic [2:0]        nib_q, nib_d;
  logic [19:0]       sh_q, sh_d;
  logic              is_rd_q, is_rd_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic              half_q, half_d;     // first write nibble held
  logic [3:0]        whi_q, whi_d;
  logic [7:0]        obuf_q, obuf_d;     // byte returned by the SRAM
  logic [3:0]        lo_q, lo_d;         // low nibble of the byte on the pins
  logic              hi_q, hi_d;         // next fall presents a high nibble
  logic              ld_q, ld_d;         // SRAM data valid this cycle
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              re_q, re_d, we_q, we_d, err_q, err_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        sdo_q, sdo_d, oen_q, oen_d;
  logic [23:0]       word;

  // Shift register contents including the nibble being sampled now.
  assign word = {sh_q, sd_q};

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    sh_d    = sh_q;
    is_rd_d = is_rd_q;
    dcnt_d  = dcnt_q;
    half_d  = half_q;
    whi_d   = whi_q;
    obuf_d  = obuf_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ld_d    = re_q;
    addr_d  = addr_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    wdata_d = wdata_q;
    sdo_d   = sdo_q;
    oen_d   = oen_q;

    if (ld_q) obuf_d = bus.mem_rdata_i;
    // Post-increment after the write strobe has been seen with its address.
    if (we_q) addr_d = addr_q + 1'b1;

    if (cs_rise) begin
      // Frame end wins over any same-cycle SCK event; a held half byte is dropped.
      state_d = ST_IDLE;
      oen_d   = 4'h0;
      half_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_d = ST_CMD;
          nib_d   = 3'd0;
        end
        ST_CMD: if (sck_rise) begin
          sh_d  = word[19:0];
          nib_d = nib_q + 3'd1;
          if (nib_q == 3'd1) begin
            nib_d = 3'd0;
            if (word[7:0] == CMD_RD || word[7:0] == CMD_WR) begin
              state_d = ST_ADDR;
              is_rd_d = (word[7:0] == CMD_RD);
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        ST_ADDR: if (sck_rise) begin
          sh_d  = word[19:0];
          nib_d = nib_q + 3'd1;
          if (nib_q == 3'(QSPI_ADDR_NIB - 1)) begin
            addr_d = word[MEM_AW-1:0];
            if (is_rd_q) begin
              state_d = ST_DUMMY;
              re_d    = 1'b1;
              dcnt_d  = 8'd0;
            end else begin
              state_d = ST_WDATA;
              half_d  = 1'b0;
            end
          end
        end
        ST_DUMMY: if (sck_rise) begin
          if (dcnt_q == 8'(DUMMY_CYC - 1)) begin
            state_d = ST_RDATA;
            hi_d    = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
        ST_RDATA: if (sck_fall) begin
          oen_d = 4'hF;
          if (hi_q) begin
            // Park the low nibble so the prefetch can overwrite obuf.
            sdo_d  = obuf_q[7:4];
            lo_d   = obuf_q[3:0];
            addr_d = addr_q + 1'b1;
            re_d   = 1'b1;
            hi_d   = 1'b0;
          end else begin
            sdo_d = lo_q;
            hi_d  = 1'b1;
          end
        end
        ST_WDATA: if (sck_rise) begin
          if (!half_q) begin
            whi_d  = sd_q;
            half_d = 1'b1;
          end else begin
            wdata_d = {whi_q, sd_q};
            we_d    = 1'b1;
            half_d  = 1'b0;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      nib_q   <= '0;
      sh_q    <= '0;
      is_rd_q <= 1'b0;
      dcnt_q  <= '0;
      half_q  <= 1'b0;
      whi_q   <= '0;
      obuf_q  <= '0;
      lo_q    <= '0;
      hi_q    <= 1'b0;
      ld_q    <= 1'b0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      sdo_q   <= '0;
      oen_q   <= '0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      sh_q    <= sh_d;
      is_rd_q <= is_rd_d;
      dcnt_q  <= dcnt_d;
      half_q  <= half_d;
      whi_q   <= whi_d;
      obuf_q  <= obuf_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      sdo_q   <= sdo_d;
      oen_q   <= oen_d;
    end
  end

  assign bus.sd_o        = sdo_q;
  assign bus.sd_oen_o    = oen_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_re_o    = re_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_exotiny_qspi_resp.sv
// Directed bench: table of read/write frames plus hand sequences for
// unknown opcode, aborts and reset mid-frame. SCK half period = 8 clk_i.
module tb_exotiny_qspi_resp;
  import exotiny_qspi_pkg::*;

  localparam int MEM_AW = 12;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exotiny_qspi_resp_if #(.MEM_AW(MEM_AW)) bus ();

  exotiny_qspi_resp #(.MEM_AW(MEM_AW), .DUMMY_CYC(6)) dut (
    .clk_i (clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  // Synchronous SRAM model.
  logic [7:0] mem [0:(1<<MEM_AW)-1];
  always @(posedge clk) begin
    if (bus.mem_re_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
  end

  // Strobe logs, sampled away from the active edge.
  logic [MEM_AW-1:0] we_a[$], re_a[$];
  logic [7:0]        we_d[$];
  int                err_cnt, both_cnt;
  logic [3:0]        oen_seen;
  always @(negedge clk) begin
    if (bus.mem_we_o) begin we_a.push_back(bus.mem_addr_o); we_d.push_back(bus.mem_wdata_o); end
    if (bus.mem_re_o) re_a.push_back(bus.mem_addr_o);
    if (bus.err_o) err_cnt++;
    if (bus.mem_re_o && bus.mem_we_o) both_cnt++;
  end

  int n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_a.delete(); we_d.delete(); re_a.delete();
    err_cnt = 0; oen_seen = 4'h0;
  endtask

  // Initiator: drive a nibble in the low phase, then one SCK pulse.
  task automatic send_nib(input logic [3:0] n);
    bus.sd_i = n;
    wait_clk(HALF);
    oen_seen = oen_seen | bus.sd_oen_o;
    bus.sck_i = 1'b1;
    wait_clk(HALF);
    bus.sck_i = 1'b0;
  endtask

  task automatic read_nib(output logic [3:0] n, output logic [3:0] oen);
    wait_clk(HALF);
    n = bus.sd_o; oen = bus.sd_oen_o;
    bus.sck_i = 1'b1;
    wait_clk(HALF);
    bus.sck_i = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] op, input logic [23:0] a);
    bus.cs_in = 1'b0;
    wait_clk(HALF);
    send_nib(op[7:4]);
    send_nib(op[3:0]);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic dummies();
    for (int i = 0; i < 6; i++) send_nib(4'h0);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    bus.cs_in = 1'b1;
    wait_clk(2*HALF);
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_sd_o"},    32'(bus.sd_o), 0);
    chk({tag, "_oen"},     32'(bus.sd_oen_o), 0);
    chk({tag, "_addr"},    32'(bus.mem_addr_o), 0);
    chk({tag, "_re"},      32'(bus.mem_re_o), 0);
    chk({tag, "_we"},      32'(bus.mem_we_o), 0);
    chk({tag, "_wdata"},   32'(bus.mem_wdata_o), 0);
    chk({tag, "_err"},     32'(bus.err_o), 0);
    chk({tag, "_state"},   32'(dut.state_q), 32'(ST_IDLE));
  endtask

  // Read a 2-byte burst, checking data nibbles and output enable.
  task automatic read_burst(input string tag, input logic [15:0] exp);
    logic [3:0] n, oen;
    dummies();
    chk({tag, "_oen_dummy"}, 32'(oen_seen), 0);
    for (int i = 0; i < 4; i++) begin
      read_nib(n, oen);
      chk($sformatf("%s_nib%0d", tag, i), 32'(n), 32'(exp[15-4*i -: 4]));
      chk($sformatf("%s_oen%0d", tag, i), 32'(oen), 32'hF);
    end
    cs_high();
    chk({tag, "_oen_after"}, 32'(bus.sd_oen_o), 0);
  endtask

  typedef struct {
    bit                wr;
    logic [23:0]       addr;
    logic [7:0]        d0, d1;   // bytes written, or bytes expected back
    logic [MEM_AW-1:0] ea0, ea1; // expected strobe addresses
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [3:0] n, oen;
    n_chk = 0; n_fail = 0; both_cnt = 0;
    clear_logs();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[12'h020] = 8'h12; mem[12'h021] = 8'h34;
    mem[12'hFFF] = 8'h5A; mem[12'h000] = 8'hC3;

    tbl[0] = '{1'b1, 24'h000010, 8'hA5, 8'h3C, 12'h010, 12'h011};
    tbl[1] = '{1'b0, 24'h000020, 8'h12, 8'h34, 12'h020, 12'h021};
    tbl[2] = '{1'b0, 24'h000FFF, 8'h5A, 8'hC3, 12'hFFF, 12'h000};
    tbl[3] = '{1'b1, 24'h123456, 8'h0F, 8'hF0, 12'h456, 12'h457};
    tbl[4] = '{1'b0, 24'h000456, 8'h0F, 8'hF0, 12'h456, 12'h457};

    bus.cs_in = 1'b1; bus.sck_i = 1'b0; bus.sd_i = 4'h0;
    rst_n = 1'b0;
    wait_clk(3);
    check_outputs_reset("reset");
    rst_n = 1'b1;
    wait_clk(4);

    for (int r = 0; r < 5; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      clear_logs();
      if (tbl[r].wr) begin
        start_cmd(QSPI_CMD_WR, tbl[r].addr);
        send_nib(tbl[r].d0[7:4]); send_nib(tbl[r].d0[3:0]);
        send_nib(tbl[r].d1[7:4]); send_nib(tbl[r].d1[3:0]);
        cs_high();
        chk({tag, "_we_cnt"}, 32'(we_a.size()), 2);
        if (we_a.size() >= 2) begin
          chk({tag, "_we0_addr"}, 32'(we_a[0]), 32'(tbl[r].ea0));
          chk({tag, "_we0_data"}, 32'(we_d[0]), 32'(tbl[r].d0));
          chk({tag, "_we1_addr"}, 32'(we_a[1]), 32'(tbl[r].ea1));
          chk({tag, "_we1_data"}, 32'(we_d[1]), 32'(tbl[r].d1));
        end
        chk({tag, "_re_cnt"}, 32'(re_a.size()), 0);
      end else begin
        start_cmd(QSPI_CMD_RD, tbl[r].addr);
        read_burst(tag, {tbl[r].d0, tbl[r].d1});
        chk({tag, "_re_min"}, 32'(re_a.size() >= 2), 1);
        if (re_a.size() >= 2) begin
          chk({tag, "_re0_addr"}, 32'(re_a[0]), 32'(tbl[r].ea0));
          chk({tag, "_re1_addr"}, 32'(re_a[1]), 32'(tbl[r].ea1));
        end
        chk({tag, "_we_cnt"}, 32'(we_a.size()), 0);
      end
      chk({tag, "_err"}, 32'(err_cnt), 0);
    end

    // Unknown opcode: one error pulse, no strobes, never drives.
    clear_logs();
    start_cmd(8'h9F, 24'h000020);
    send_nib(4'h0); send_nib(4'h0);
    chk("badop_oen_before_cs", 32'(oen_seen | bus.sd_oen_o), 0);
    cs_high();
    chk("badop_err", 32'(err_cnt), 1);
    chk("badop_re", 32'(re_a.size()), 0);
    chk("badop_we", 32'(we_a.size()), 0);

    // Single write nibble then CS rise: nothing written.
    clear_logs();
    start_cmd(QSPI_CMD_WR, 24'h000100);
    send_nib(4'h7);
    cs_high();
    chk("partial_we", 32'(we_a.size()), 0);

    // CS rise mid-read: output enable drops after the sync+detect+register latency.
    clear_logs();
    start_cmd(QSPI_CMD_RD, 24'h000020);
    dummies();
    read_nib(n, oen);
    chk("abort_nib", 32'(n), 32'h1);
    wait_clk(2);
    chk("abort_oen_pre", 32'(bus.sd_oen_o), 32'hF);
    bus.cs_in = 1'b1;
    wait_clk(4);
    chk("abort_oen_post", 32'(bus.sd_oen_o), 0);
    wait_clk(2*HALF);
    clear_logs();
    start_cmd(QSPI_CMD_RD, 24'h000020);
    read_burst("after_abort", 16'h1234);

    // Reset in RDATA: outputs return to reset values without a clock edge.
    clear_logs();
    start_cmd(QSPI_CMD_RD, 24'h000FFF);
    dummies();
    read_nib(n, oen);
    chk("rstmid_oen_pre", 32'(oen), 32'hF);
    rst_n = 1'b0;
    #2;
    check_outputs_reset("rstmid");
    bus.cs_in = 1'b1; bus.sck_i = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    clear_logs();
    start_cmd(QSPI_CMD_RD, 24'h000020);
    read_burst("after_rst", 16'h1234);

    chk("strobe_overlap", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
